// File: rtl/des_round_sequencer.sv
// Control FSM for an iterative DES engine: sequences load, rounds with key-rotation schedule, final capture and output handshake.
// Optional DES_RND_ACK_EN: each round is held until the datapath acknowledges it (multi-cycle rounds).
module des_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_decrypt,
  output logic             in_ready,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic [1:0]       dp_shift_amt,
  output logic             dp_shift_dir,
  output logic             dp_final_en,
  input  logic             dp_rnd_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             dec, dec_nxt;
  logic             advance;

  // Decrypt starts one rotation short: the LOAD-time PC-1 state already equals K16's C/D.
  function automatic logic [1:0] shift_amt_f(input logic [IDX_W-1:0] i, input logic d);
    int unsigned n;
    n = 32'(i);
    if (n == 0)                        return d ? 2'd0 : 2'd1;
    if (n == 1 || n == 8 || n == 15)   return 2'd1;
    return 2'd2;
  endfunction

`ifdef DES_RND_ACK_EN
  assign advance = dp_rnd_ack;
`else
  logic unused_ack;
  assign unused_ack = dp_rnd_ack;
  assign advance    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      dec   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dec   <= dec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dec_nxt   = dec;
    case (state)
      IDLE: begin
        if (in_valid) begin
          dec_nxt   = in_decrypt;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        idx_nxt   = '0;
        state_nxt = ROUND;
      end
      ROUND: begin
        if (advance) begin
          if (idx == IDX_W'(ROUNDS - 1)) begin
            idx_nxt   = '0;
            state_nxt = FINAL;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      FINAL:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b1;
    dp_load      = 1'b0;
    dp_round_en  = 1'b0;
    dp_final_en  = 1'b0;
    out_valid    = 1'b0;
    dp_shift_amt = 2'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOAD:  dp_load = 1'b1;
      ROUND: begin
        dp_round_en  = 1'b1;
        dp_shift_amt = shift_amt_f(idx, dec);
      end
      FINAL:   dp_final_en = 1'b1;
      DONE:    out_valid   = 1'b1;
      default: ;
    endcase
  end

  assign dp_round_idx = idx;
  assign dp_shift_dir = dec;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Scoreboard bench for des_round_sequencer: driver pushes the expected event timeline per block, monitor pops and compares.
module tb_des_round_sequencer;

  localparam int K_LOAD = 0, K_ROUND = 1, K_FINAL = 2, K_VALID = 3;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_decrypt, out_ready, dp_rnd_ack;
  logic       in_ready, dp_load, dp_round_en, dp_shift_dir, dp_final_en, out_valid, busy;
  logic [3:0] dp_round_idx;
  logic [1:0] dp_shift_amt;

  typedef struct {int kind; int cyc; int idx; int amt; bit dir;} ev_t;
  ev_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int amt_sum = 0;
  logic ov_e = 1'b0, or_e = 1'b0;

  int enc_tab[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_tab[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  des_round_sequencer #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_decrypt(in_decrypt),
    .in_ready(in_ready), .dp_load(dp_load), .dp_round_en(dp_round_en),
    .dp_round_idx(dp_round_idx), .dp_shift_amt(dp_shift_amt), .dp_shift_dir(dp_shift_dir),
    .dp_final_en(dp_final_en), .dp_rnd_ack(dp_rnd_ack), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ov_e <= out_valid;
    or_e <= out_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      if (kind == K_ROUND) chk("round_idx", 32'(dp_round_idx), e.idx);
      chk("shift_amt", 32'(dp_shift_amt), e.amt);
      chk("shift_dir", 32'(dp_shift_dir), 32'(e.dir));
      if (kind == K_FINAL) chk("amt_sum", amt_sum, e.dir ? 27 : 28);
    end
  endtask

  // Monitor: invariants every cycle plus scoreboard pops on each datapath/output event.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (!dp_round_en) chk("amt_outside_round", 32'(dp_shift_amt), 0);
      if (ov_e) begin
        if (or_e) chk("release", {out_valid, in_ready}, 2'b01);
        else      chk("hold", 32'(out_valid), 1);
      end
      if (dp_load) begin
        amt_sum = 0;
        got(K_LOAD);
      end
      if (dp_round_en) begin
        amt_sum += 32'(dp_shift_amt);
        got(K_ROUND);
      end
      if (dp_final_en) got(K_FINAL);
      if (out_valid && !ov_e) got(K_VALID);
    end
  end

  task automatic push_block(input bit dec, input int c);
    sb.push_back('{K_LOAD, c + 1, 0, 0, dec});
    for (int k = 0; k < 16; k++)
      sb.push_back('{K_ROUND, c + 2 + k, k, dec ? dec_tab[k] : enc_tab[k], dec});
    sb.push_back('{K_FINAL, c + 18, 0, 0, dec});
    sb.push_back('{K_VALID, c + 19, 0, 0, dec});
  endtask

  task automatic issue(input bit dec, input bit hold);
    int n = 0;
    in_decrypt = dec;
    in_valid   = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else push_block(dec, cyc);
    @(negedge clk);
    if (!hold) begin
      in_valid   = 1'b0;
      in_decrypt = !dec;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size() == 0 && in_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {in_ready, busy, dp_load, dp_round_en, dp_final_en, out_valid,
               dp_round_idx, dp_shift_amt, dp_shift_dir},
        {6'b100000, 4'd0, 2'd0, 1'b0});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b1; dp_rnd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Encrypt, then decrypt, with out_ready already high.
    issue(1'b0, 1'b0);
    drain();
    issue(1'b1, 1'b0);
    drain();

    // Output stall of five cycles.
    out_ready = 1'b0;
    issue(1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid_ready", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_handshake", {out_valid, in_ready}, 2'b01);
    drain();

    // in_valid held continuously across two blocks.
    issue(1'b1, 1'b1);
    chk("busy_after_accept", 32'(in_ready), 0);
    issue(1'b1, 1'b0);
    drain();

    // Asynchronous reset in the middle of round 7 of a decrypt block.
    issue(1'b1, 1'b0);
    n = 0;
    while (!(dp_round_en && dp_round_idx == 4'd7) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx7", 32'(dp_round_idx), 7);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_op_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_after_reset", {in_ready, out_valid}, 2'b10);

    // Recovery block after reset.
    issue(1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
